// File: rtl/code_sequencer_if.sv
// Load-stream valid/ready port of code_sequencer.
// master streams program words, slave accepts them.
interface code_sequencer_if #(
  parameter int W = 12
) ();
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/code_sequencer.sv
// Loads a program into code_storage, then fetches it one line per step.
// Optional halt-word termination: CODE_SEQUENCER_HALT_DETECT_EN.
module code_sequencer #(
  parameter int                    code_size     = 12,
  parameter int                    max_code_line = 100,
  parameter logic [code_size-1:0]  halt_code     = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [31:0]          load_len,
  code_sequencer_if.slave      in_if,
  input  logic                 step,
  output logic [code_size-1:0] core_code,
  output logic                 core_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 st_is_write,
  output logic [31:0]          st_write_line,
  output logic [code_size-1:0] st_write_data,
  output logic                 st_enable,
  output logic                 st_active,
  output logic                 st_reset,
  input  logic [code_size-1:0] st_code
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] wr_q, wr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] len_q, len_d;
  logic        adv_q, adv_d;
  logic        err_q, err_d;

  logic        bad_len;
  logic        halt_hit;

  assign bad_len = (load_len == 32'd0) ||
                   (load_len > 32'(max_code_line));

`ifdef CODE_SEQUENCER_HALT_DETECT_EN
  assign halt_hit = (st_code == halt_code);
`else
  logic unused_halt;
  assign unused_halt = ^halt_code;
  assign halt_hit    = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      adv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      adv_q   <= adv_d;
      err_q   <= err_d;
    end
  end

  // next-state logic and storage/core outputs
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    pc_d          = pc_q;
    len_d         = len_q;
    adv_d         = 1'b0;
    err_d         = err_q;
    in_if.in_ready = 1'b0;
    st_is_write   = 1'b0;
    st_write_line = '0;
    st_write_data = '0;
    st_enable     = 1'b0;
    st_active     = 1'b0;
    st_reset      = 1'b0;
    core_valid    = 1'b0;
    core_code     = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          if (bad_len) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            len_d   = load_len;
            err_d   = 1'b0;
            wr_d    = '0;
            pc_d    = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        in_if.in_ready = 1'b1;
        if (in_if.in_valid) begin
          st_is_write   = 1'b1;
          st_write_line = wr_q;
          st_write_data = in_if.in_data;
          wr_d          = wr_q + 32'd1;
          if (wr_q == len_q - 32'd1)
            state_d = START;
        end
      end
      START: begin
        st_enable = 1'b1;
        st_reset  = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        st_enable  = 1'b1;
        st_active  = adv_q;
        core_valid = !adv_q;
        core_code  = st_code;
        if (step && !adv_q) begin
          if ((pc_q == len_q - 32'd1) || halt_hit) begin
            state_d = DONE;
          end else begin
            adv_d = 1'b1;
            pc_d  = pc_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == LOAD) || (state_q == START) ||
                 (state_q == RUN);
  assign done  = (state_q == DONE);
  assign error = err_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer with a behavioural code_storage.
// Inputs change 1ns after posedge, outputs sampled at negedge.
module tb_code_sequencer;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [31:0] load_len;
  logic        step;
  logic [11:0] core_code;
  logic        core_valid;
  logic        busy;
  logic        done;
  logic        error;
  logic        st_is_write;
  logic [31:0] st_write_line;
  logic [11:0] st_write_data;
  logic        st_enable;
  logic        st_active;
  logic        st_reset;
  logic [11:0] st_code;

  int chk_cnt = 0;
  int pass_cnt = 0;

  code_sequencer_if #(.W(12)) in_if ();

  code_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .load_len      (load_len),
    .in_if         (in_if),
    .step          (step),
    .core_code     (core_code),
    .core_valid    (core_valid),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .st_is_write   (st_is_write),
    .st_write_line (st_write_line),
    .st_write_data (st_write_data),
    .st_enable     (st_enable),
    .st_active     (st_active),
    .st_reset      (st_reset),
    .st_code       (st_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // storage model: index reset / advance, 0-latency write
  logic [11:0] mem [128];
  logic [31:0] idx = 0;
  assign st_code = mem[idx[6:0]];

  always @(posedge clk) begin
    if (st_is_write)
      mem[st_write_line[6:0]] <= st_write_data;
    if (st_enable) begin
      if (st_reset)
        idx <= 0;
      else if (st_active)
        idx <= idx + 1;
    end
  end

  // write log
  logic [31:0] wr_line [64];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (st_is_write) begin
      if (wr_cnt < 64)
        wr_line[wr_cnt] <= st_write_line;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] n);
    load_start = 1'b1;
    load_len   = n;
    cyc();
    load_start = 1'b0;
    load_len   = '0;
  endtask

  task automatic feed(input int n, input logic [59:0] w);
    for (int i = 0; i < n; i++) begin
      in_if.in_valid = 1'b1;
      in_if.in_data  = w[i*12 +: 12];
      cyc();
    end
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    #2;
    o = {busy, done, error, core_valid, st_enable, in_if.in_ready};
    chk_cnt++;
    if (o !== 6'b0 || core_code !== 12'h0 || st_is_write !== 1'b0)
      $display("FAIL reset_outs: got %b code=%h want 0", o, core_code);
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    logic [35:0] w;
    int          base;
    w = {12'h033, 12'h022, 12'h011};
    base = wr_cnt;
    start_load(3);
    #4;
    chk_cnt++;
    if (in_if.in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_ready: got %b want 1", in_if.in_ready);
    else pass_cnt++;
    feed(3, {24'h0, w});
    #4;
    chk_cnt++;
    if (st_reset !== 1'b1 || st_enable !== 1'b1 || wr_cnt - base != 3)
      $display("FAIL basic_start: got rst=%b en=%b wr=%0d want 1 1 3",
               st_reset, st_enable, wr_cnt - base);
    else pass_cnt++;
    step = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      #4;
      chk_cnt++;
      if (core_valid !== 1'b1 || core_code !== w[i*12 +: 12])
        $display("FAIL basic_word%0d: got v=%b %h want v=1 %h",
                 i, core_valid, core_code, w[i*12 +: 12]);
      else pass_cnt++;
      cyc();
      #4;
      chk_cnt++;
      if (i == 2) begin
        if (done !== 1'b1 || core_valid !== 1'b0 || busy !== 1'b0)
          $display("FAIL basic_done: got d=%b v=%b want 1 0",
                   done, core_valid);
        else pass_cnt++;
      end else begin
        if (core_valid !== 1'b0 || st_active !== 1'b1)
          $display("FAIL basic_bubble%0d: got v=%b act=%b want 0 1",
                   i, core_valid, st_active);
        else pass_cnt++;
      end
      cyc();
    end
    step = 1'b0;
  endtask

  task automatic test_illegal_len();
    start_load(0);
    #4;
    chk_cnt++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        in_if.in_ready !== 1'b0)
      $display("FAIL illegal0: got e=%b b=%b d=%b r=%b want 1 0 0 0",
               error, busy, done, in_if.in_ready);
    else pass_cnt++;
    cyc();
    start_load(101);
    #4;
    chk_cnt++;
    if (error !== 1'b1 || busy !== 1'b0 || in_if.in_ready !== 1'b0)
      $display("FAIL illegal101: got e=%b b=%b r=%b want 1 0 0",
               error, busy, in_if.in_ready);
    else pass_cnt++;
    cyc();
    start_load(1);
    #4;
    chk_cnt++;
    if (error !== 1'b0 || in_if.in_ready !== 1'b1)
      $display("FAIL illegal_clear: got e=%b r=%b want 0 1",
               error, in_if.in_ready);
    else pass_cnt++;
    feed(1, 60'h0ab);
    step = 1'b1;
    cyc();
    #4;
    chk_cnt++;
    if (core_valid !== 1'b1 || core_code !== 12'h0ab)
      $display("FAIL len1_word: got v=%b %h want 1 0ab",
               core_valid, core_code);
    else pass_cnt++;
    cyc();
    #4;
    chk_cnt++;
    if (done !== 1'b1)
      $display("FAIL len1_done: got %b want 1", done);
    else pass_cnt++;
    cyc();
    step = 1'b0;
  endtask

  task automatic test_stall();
    logic [5:0]  pat;
    logic [71:0] dat;
    int          base;
    int          k;
    pat = 6'b101001;
    dat = {12'h505, 12'hbad, 12'h303, 12'hbad, 12'hbad, 12'h101};
    base = wr_cnt;
    k = 0;
    start_load(3);
    for (int i = 0; i < 6; i++) begin
      in_if.in_valid = pat[i];
      in_if.in_data  = dat[i*12 +: 12];
      load_start     = (i == 1);
      load_len       = '0;
      #4;
      chk_cnt++;
      if (st_is_write !== pat[i] ||
          (pat[i] && st_write_line !== 32'(k)))
        $display("FAIL stall_wr%0d: got we=%b line=%0d want %b %0d",
                 i, st_is_write, st_write_line, pat[i], k);
      else pass_cnt++;
      if (pat[i]) k++;
      cyc();
    end
    in_if.in_valid = 1'b0;
    load_start     = 1'b0;
    #4;
    chk_cnt++;
    if (st_reset !== 1'b1 || error !== 1'b0 || wr_cnt - base != 3)
      $display("FAIL stall_start: got rst=%b e=%b wr=%0d want 1 0 3",
               st_reset, error, wr_cnt - base);
    else pass_cnt++;
    chk_cnt++;
    if (wr_line[base] !== 0 || wr_line[base+1] !== 1 ||
        wr_line[base+2] !== 2)
      $display("FAIL stall_lines: got %0d %0d %0d want 0 1 2",
               wr_line[base], wr_line[base+1], wr_line[base+2]);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_reset_mid_run();
    logic [11:0] o;
    logic [23:0] w;
    #4;
    chk_cnt++;
    if (core_valid !== 1'b1 || core_code !== 12'h101)
      $display("FAIL rst_run0: got v=%b %h want 1 101",
               core_valid, core_code);
    else pass_cnt++;
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    #2;
    chk_cnt++;
    if (core_valid !== 1'b1 || core_code !== 12'h303)
      $display("FAIL rst_run1: got v=%b %h want 1 303",
               core_valid, core_code);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    o = {busy, done, error, core_valid, st_enable, st_active,
         st_reset, st_is_write, in_if.in_ready, 3'b0};
    chk_cnt++;
    if (o !== 12'h0 || core_code !== 12'h0 || st_write_line !== 0)
      $display("FAIL rst_async: got %b code=%h want 0", o, core_code);
    else pass_cnt++;
    cyc();
    reset = 1'b0;
    cyc();
    w = {12'h0c2, 12'h0c1};
    start_load(2);
    feed(2, {36'h0, w});
    step = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      #4;
      chk_cnt++;
      if (core_valid !== 1'b1 || core_code !== w[i*12 +: 12])
        $display("FAIL rst_new%0d: got v=%b %h want 1 %h",
                 i, core_valid, core_code, w[i*12 +: 12]);
      else pass_cnt++;
      cyc();
      cyc();
    end
    #4;
    chk_cnt++;
    if (done !== 1'b1)
      $display("FAIL rst_new_done: got %b want 1", done);
    else pass_cnt++;
    cyc();
    step = 1'b0;
  endtask

  task automatic test_halt();
    start_load(3);
    feed(3, {24'h0, 12'h007, 12'h000, 12'h005});
    step = 1'b1;
    cyc();
    #4;
    chk_cnt++;
    if (core_valid !== 1'b1 || core_code !== 12'h005)
      $display("FAIL halt_w0: got v=%b %h want 1 005",
               core_valid, core_code);
    else pass_cnt++;
    cyc();
    cyc();
    #4;
    chk_cnt++;
    if (core_valid !== 1'b1 || core_code !== 12'h000)
      $display("FAIL halt_w1: got v=%b %h want 1 000",
               core_valid, core_code);
    else pass_cnt++;
    cyc();
    #4;
`ifdef CODE_SEQUENCER_HALT_DETECT_EN
    chk_cnt++;
    if (done !== 1'b1 || core_valid !== 1'b0)
      $display("FAIL halt_stop: got d=%b v=%b want 1 0",
               done, core_valid);
    else pass_cnt++;
    cyc();
    #4;
    chk_cnt++;
    if (done !== 1'b1 || core_valid !== 1'b0)
      $display("FAIL halt_no007: got d=%b v=%b want 1 0",
               done, core_valid);
    else pass_cnt++;
    cyc();
`else
    chk_cnt++;
    if (done !== 1'b0 || core_valid !== 1'b0)
      $display("FAIL nohalt_bubble: got d=%b v=%b want 0 0",
               done, core_valid);
    else pass_cnt++;
    cyc();
    #4;
    chk_cnt++;
    if (core_valid !== 1'b1 || core_code !== 12'h007)
      $display("FAIL nohalt_w2: got v=%b %h want 1 007",
               core_valid, core_code);
    else pass_cnt++;
    cyc();
    #4;
    chk_cnt++;
    if (done !== 1'b1)
      $display("FAIL nohalt_done: got %b want 1", done);
    else pass_cnt++;
    cyc();
`endif
    step = 1'b0;
  endtask

  task automatic test_reload();
    logic [23:0] w;
    w = {12'h0d2, 12'h0d1};
    load_start = 1'b1;
    load_len   = 2;
    #4;
    chk_cnt++;
    if (done !== 1'b1)
      $display("FAIL reload_pre: got done=%b want 1", done);
    else pass_cnt++;
    cyc();
    load_start = 1'b0;
    #4;
    chk_cnt++;
    if (done !== 1'b0 || in_if.in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL reload_load: got d=%b r=%b want 0 1",
               done, in_if.in_ready);
    else pass_cnt++;
    feed(2, {36'h0, w});
    step = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      #4;
      chk_cnt++;
      if (core_valid !== 1'b1 || core_code !== w[i*12 +: 12])
        $display("FAIL reload_w%0d: got v=%b %h want 1 %h",
                 i, core_valid, core_code, w[i*12 +: 12]);
      else pass_cnt++;
      cyc();
      cyc();
    end
    #4;
    chk_cnt++;
    if (done !== 1'b1)
      $display("FAIL reload_done: got %b want 1", done);
    else pass_cnt++;
    cyc();
    step = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = 12'heee;
    reset          = 1'b1;
    load_start     = 1'b0;
    load_len       = '0;
    step           = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    test_reset();
    test_basic();
    test_illegal_len();
    test_stall();
    test_reset_mid_run();
    test_halt();
    test_reload();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/code_sequencer.md
# code_sequencer

Controller that owns the `code_storage` instance of a neural-burning core. It loads a program streamed in over a valid/ready port into consecutive storage lines. It then sequences instruction fetch for the execution core one line per `step` request, and signals completion. It is the only driver of the storage write and control pins; during execution the core sees only `core_code` and `core_valid`.

## Interface
- `code_size`, 12, width of one code word; matches storage.
- `max_code_line`, 100, number of usable storage lines; programs longer than this are rejected.
- `halt_code`, 0, code word value that terminates RUN when halt detection is compiled in.

- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `load_start` in 1: single-cycle request to begin loading; sampled in IDLE and DONE only.
- `load_len` in 32: program length in words; sampled with `load_start`.
- `in_valid` in 1: load stream word valid.
- `in_data` in code_size: load stream word.
- `in_ready` out 1: high throughout LOAD.
- `step` in 1: core consumed the current word and wants the next.
- `core_code` out code_size: current instruction; equals `st_code`.
- `core_valid` out 1: `core_code` is stable and consumable.
- `busy` out 1: state is LOAD, START or RUN.
- `done` out 1: level, high in DONE.
- `error` out 1: sticky; set on illegal `load_len`, cleared by the next accepted `load_start`.
- `st_is_write`, `st_write_line`[32], `st_write_data`[code_size] out: storage write port.
- `st_enable`, `st_active`, `st_reset` out 1: storage control pins.
- `st_code` in code_size: storage `code` output.

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
- Reset behaviour:
  - Asynchronous reset forces IDLE.
  - Internal `wr_ptr`, `pc`, `len` and `adv_q` clear to 0.
  - All outputs read 0.
- Handling `load_start` in IDLE or DONE:
  - If `load_len` is 0 or greater than `max_code_line`, set `error` and go to or stay in IDLE.
  - Otherwise latch `len`, clear `error`, `wr_ptr` and `pc`, and go to LOAD.
  - `load_start` is ignored in LOAD, START and RUN.
- LOAD:
  - `in_ready` is 1.
  - On `in_valid` with `in_ready`, `st_is_write` is 1 that cycle (combinational), with `st_write_line` = `wr_ptr` and `st_write_data` = `in_data`.
  - `wr_ptr` increments on each accepted word.
  - The accept with `wr_ptr == len-1` moves to START.
  - `st_enable` is 0 and `in_data` is ignored when `in_valid` is low.
- START:
  - Lasts one cycle.
  - Drives `st_enable` = 1 and `st_reset` = 1, so the storage index latches 0.
  - Then goes to RUN.
- RUN:
  - Drives `st_enable` = 1 and `st_active` = `adv_q`.
  - `core_valid` = !`adv_q`.
  - On `step` while `core_valid`:
    - If `pc == len-1`, go to DONE.
    - Otherwise set `adv_q` and increment `pc`.
  - `adv_q` self-clears the next cycle.
  - `step` while `core_valid` is 0 is ignored.
- DONE:
  - `done` is 1.
  - `st_enable` is 0 and `core_valid` is 0.
- No writes occur outside LOAD, so read/write forwarding in storage is never exercised during RUN.
- Arithmetic:
  - `wr_ptr`, `pc` and `len` are 32-bit unsigned.
  - The `len` bound check guarantees no wrap.

## Timing
- `in_ready` and `st_is_write` are combinational from state and `in_valid`. Write latency is 0 cycles; the storage line updates at the accepting edge.
- Load to run:
  - Last word accepted at edge N gives START in cycle N+1.
  - RUN starts in cycle N+2, with `core_valid` = 1 and `core_code` = line 0.
- Each `step` costs one bubble cycle. With `step` at edge K, `core_valid` = 0 in cycle K+1 (storage advancing) and `core_valid` = 1 with the next word in cycle K+2. Peak fetch rate is 1 word per 2 cycles.
- `done` rises the cycle after the terminating `step`.
- A reset asserted mid-LOAD or mid-RUN aborts immediately. Already-written lines remain in storage but are not trusted.

## Configuration
- `CODE_SEQUENCER_HALT_DETECT_EN` defined:
  - A `step` accepted while `core_code == halt_code` goes to DONE regardless of `pc`.
  - Reaching `len` also terminates.
- Undefined: RUN terminates only at `pc == len-1`, and `halt_code` is unused.

## Test plan
- Basic load and run: `load_len`=3 and words 0x011, 0x022, 0x033 streamed back-to-back, then `step` held high. Required: `core_code` shows 0x011, 0x022, 0x033 on consecutive `core_valid` cycles 2 cycles apart, and `done` is 1 the cycle after the third step.
- Illegal length: `load_len`=0, then `load_len`=101. Required: `error`=1 each time, state stays IDLE, `in_ready` stays 0, and a following `load_len`=1 clears `error`.
- Stalled input: `in_valid` toggled 1,0,0,1,0,1 for `load_len`=3. Required: exactly 3 writes to lines 0, 1, 2, with START following the third accept.
- Halt code with the macro on: program 0x005, 0x000, 0x007 with `halt_code`=0. Required: DONE after the second step and 0x007 never presented. With the macro off, all 3 words are presented.
- Reset mid-operation: reset asserted in RUN at `pc`=1. Required: all outputs 0 asynchronously, and a new load of 2 words runs from line 0.
- Reload from DONE: `load_start` in DONE with `load_len`=2. Required: LOAD entered, `done` drops the next cycle, and the new words are fetched in order.
